entropy_collector: RTL and testbench
====================================

ENTROPY_COLLECTOR -- requirements
Module: entropy_collector

Interface
REQ-001 Parameter WORD_W, default 64, sets the output word width in bits; legal range 8..64.
REQ-002 Parameter SAMPLE_DIV, default 8, sets the clocks between raw samples of the entropy input; legal range 1..256.
REQ-003 Parameter RCT_CUTOFF, default 32, sets the repetition-count health-test cutoff on raw samples; legal range 2..255.
REQ-004 Port clk, input, 1, is the single clock for all state.
REQ-005 Port reset_n, input, 1, is an asynchronous active-low reset.
REQ-006 Port enable, input, 1, enables collection; low means idle and clear, as defined in REQ-017.
REQ-007 Port entropy, input, 1, is the raw oscillator XOR bit from the upstream ring-oscillator source, asynchronous to clk.
REQ-008 Port data, output, WORD_W, is the collected debiased word.
REQ-009 Port data_valid, output, 1, is high while data holds an unconsumed word.
REQ-010 Port data_ready, input, 1, is the consumer accept signal; a transfer occurs on a clk edge where data_valid=1 and data_ready=1.
REQ-011 Port rct_fail, output, 1, is the sticky repetition-count health-test failure flag.

Function
REQ-012 entropy SHALL pass through a 2-flop synchronizer before any use; all uses below refer to the synchronized bit.
REQ-013 Sampling: a divider counts 0..SAMPLE_DIV-1 while enable=1; a sample strobe occurs on the cycle the count equals SAMPLE_DIV-1, after which the count wraps to 0 (SAMPLE_DIV=1 gives a strobe every cycle).
REQ-014 Von Neumann debiasing uses two states:
  - FIRST: latch the sample into b0 and go to SECOND.
  - SECOND: sample b1 and return to FIRST; if b0!=b1, emit b0 as one debiased bit; if b0==b1, emit nothing.
REQ-015 Packing:
  - Each debiased bit shifts into the LSB of a WORD_W shift register, and a bit counter (0..WORD_W) increments.
  - When the counter reaches WORD_W and the output register is empty, or is emptied by a transfer on that same edge, the shift register SHALL load into data, data_valid SHALL be set, and the counter SHALL clear in that same cycle.
REQ-016 Backpressure: while the counter equals WORD_W and data_valid=1 with no transfer, further debiased bits are discarded and the counter holds; no bit already in the shift register is lost.
REQ-017 enable=0 SHALL clear the divider, the debias state (to FIRST), the bit counter and the RCT counter on the next edge; data/data_valid SHALL retain a pending word until it is transferred.
REQ-018 A transfer with no new word ready on the same edge SHALL clear data_valid; data SHALL hold its last value.
REQ-019 RCT:
  - The test operates on raw (pre-debias) samples.
  - The run counter resets to 1 on a sample differing from the previous one and increments, saturating at 255, on an equal sample.
  - When the run reaches RCT_CUTOFF, rct_fail SHALL be set on that edge.
REQ-020 While rct_fail=1, no new word SHALL be loaded into data: the shift register and counter clear and stay cleared, and any pending word is still deliverable.
REQ-021 rct_fail SHALL clear only on reset or on a clk edge where enable=0.
REQ-022 data_valid SHALL NOT depend combinationally on data_ready.

Reset
REQ-023 While reset_n=0: data=0, data_valid=0, rct_fail=0, the synchronizer flops=0, the divider=0, the debias state=FIRST, the bit counter=0 and the RCT counter=0.
REQ-024 Deassertion of reset_n takes effect on the next clk edge; a reset asserted mid-word SHALL discard the partial word and any pending word.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
  - Basic pack: WORD_W=8, SAMPLE_DIV=1, entropy pattern 10 repeated (after sync), data_ready=1 -> data=8'hFF, data_valid asserts after 16 strobes plus the 2-cycle sync latency.
  - Debias discard: raw pairs 00,11,00,11 -> no bits packed and data_valid stays 0; pair 01 -> one 0 bit packed.
  - Backpressure: data_ready=0 through two full words -> the first word holds stable, the second fills the shift register, extra bits are discarded; raise data_ready for 1 cycle -> the second word loads the same edge and data_valid stays 1.
  - RCT: RCT_CUTOFF=4, entropy held at 1 -> rct_fail=1 on the 4th sample, with no new words afterward; pulse enable low for 1 cycle -> rct_fail=0.
  - Enable drop mid-word: 5 of 8 bits collected, enable=0 for 1 cycle, then resume -> the next word contains only bits collected after resume.
  - Async reset mid-word with data_valid=1 -> data=0 and data_valid=0 immediately, independent of clk.

Source files
------------

// File: rtl/entropy_collector_if.sv
// entropy_collector_if: valid/ready word bus from the collector to its consumer
//   data       : collected debiased word
//   data_valid : data holds an unconsumed word
//   data_ready : consumer accepts the word on an edge where data_valid is high
interface entropy_collector_if #(
    parameter int WORD_W = 64
);
    logic [WORD_W-1:0] data;
    logic              data_valid;
    logic              data_ready;
    modport master (output data, data_valid, input data_ready);
    modport slave  (input data, data_valid, output data_ready);
endinterface

// File: rtl/entropy_collector.sv
// entropy_collector: samples a ring-oscillator bit, von Neumann debiases it and packs words
//   clk, reset_n : clock and asynchronous active-low reset
//   enable       : collect when high; low clears collection state and the health flag
//   entropy      : raw asynchronous oscillator bit
//   bus          : data/data_valid out, data_ready in
//   rct_fail     : sticky repetition-count health-test failure
module entropy_collector #(
    parameter int WORD_W     = 64,
    parameter int SAMPLE_DIV = 8,
    parameter int RCT_CUTOFF = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                entropy,
    entropy_collector_if.master bus,
    output logic                rct_fail
);
    localparam int DW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW = $clog2(WORD_W + 1);
    typedef enum logic {FIRST, SECOND} state_t;
    state_t            r_state, w_state_next;
    logic [1:0]        r_sync;
    logic [DW-1:0]     r_div;
    logic              r_b0, r_prev, r_fail, r_valid;
    logic [7:0]        r_run, w_run_next;
    logic [WORD_W-1:0] r_shift, r_data;
    logic [CW-1:0]     r_cnt;
    logic              w_bit, w_stb, w_emit, w_full, w_xfer, w_load;
    assign w_bit    = r_sync[1];
    assign w_stb    = enable && r_div == DW'(SAMPLE_DIV - 1);
    assign w_full   = r_cnt == CW'(WORD_W);
    assign w_xfer   = r_valid && bus.data_ready;
    // A full shift register moves out only when the output slot is free or freeing now.
    assign w_load   = w_full && !r_fail && (!r_valid || w_xfer);
    // Run length restarts on the first sample after enable (r_run==0) or on a change.
    assign w_run_next = (r_run == 8'd0 || w_bit != r_prev) ? 8'd1 :
                        (r_run == 8'd255) ? r_run : r_run + 8'd1;
    assign bus.data       = r_data;
    assign bus.data_valid = r_valid;
    assign rct_fail       = r_fail;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= FIRST;
        else          r_state <= w_state_next;
    end
    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        if (!enable) w_state_next = FIRST;
        else if (w_stb) begin
            w_state_next = r_state == FIRST ? SECOND : FIRST;
            w_emit       = r_state == SECOND && r_b0 != w_bit;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_div   <= '0;
            r_b0    <= 1'b0;
            r_prev  <= 1'b0;
            r_run   <= '0;
            r_fail  <= 1'b0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], entropy};
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_xfer) r_valid <= 1'b0;
            if (!enable) begin
                r_div   <= '0;
                r_run   <= '0;
                r_fail  <= 1'b0;
                r_shift <= '0;
                r_cnt   <= '0;
            end else begin
                r_div <= w_stb ? '0 : r_div + 1'b1;
                if (w_stb) begin
                    r_prev <= w_bit;
                    r_run  <= w_run_next;
                    if (r_state == FIRST) r_b0 <= w_bit;
                    if (w_run_next >= 8'(RCT_CUTOFF)) r_fail <= 1'b1;
                end
                if (r_fail) begin
                    r_shift <= '0;
                    r_cnt   <= '0;
                end else if (w_load) r_cnt <= '0;
                // Bits arriving while the shift register is full are dropped.
                else if (w_emit && !w_full) begin
                    r_shift <= {r_shift[WORD_W-2:0], r_b0};
                    r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_entropy_collector.sv
// tb_entropy_collector: directed checks of packing, debiasing, backpressure, health test and reset
module tb_entropy_collector;
    logic       clk, reset_n, enable, entropy, rct_fail;
    int         checks, failures, nvalid, fail_at;
    logic       seen;
    logic [7:0] seen_data;
    entropy_collector_if #(.WORD_W(8)) bus();
    entropy_collector #(.WORD_W(8), .SAMPLE_DIV(1), .RCT_CUTOFF(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .entropy(entropy),
        .bus(bus), .rct_fail(rct_fail)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Sample i (LSB first) is pat[i]; entropy leads its sample by the two synchronizer stages.
    task automatic run(input logic [63:0] pat, input logic [63:0] en, input int n);
        seen = 1'b0;
        seen_data = '0;
        nvalid = 0;
        fail_at = -1;
        enable = 1'b0;
        entropy = pat[0];
        tick();
        entropy = pat[1];
        tick();
        for (int i = 0; i < n; i++) begin
            enable = en[i];
            entropy = pat[i + 2];
            tick();
            if (bus.data_valid) begin
                nvalid++;
                if (!seen) begin
                    seen = 1'b1;
                    seen_data = bus.data;
                end
            end
            if (rct_fail && fail_at < 0) fail_at = i;
        end
    endtask
    task automatic idle();
        enable = 1'b0;
        tick();
    endtask
    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        enable = 1'b0;
        entropy = 1'b0;
        bus.data_ready = 1'b0;
        tick();
        tick();
        chk("rst_data", 64'(bus.data), 64'h0);
        chk("rst_valid", 64'(bus.data_valid), 64'h0);
        chk("rst_fail", 64'(rct_fail), 64'h0);
        reset_n = 1'b1;
        tick();
        // basic pack: pairs 10 -> eight 1 bits
        bus.data_ready = 1'b1;
        run(64'h5_5555, '1, 18);
        idle();
        chk("pack_seen", 64'(seen), 64'h1);
        chk("pack_data", 64'(seen_data), 64'hFF);
        chk("pack_valid_after", 64'(bus.data_valid), 64'h0);
        chk("pack_data_hold", 64'(bus.data), 64'hFF);
        // equal pairs only: nothing packs
        run(64'hCCCC, '1, 12);
        idle();
        chk("discard_nvalid", 64'(nvalid), 64'h0);
        // 00,11,00,11 dropped, 01 gives one 0, then seven 1s
        run(64'h0555_56CC, '1, 26);
        idle();
        chk("discard_seen", 64'(seen), 64'h1);
        chk("discard_data", 64'(seen_data), 64'h7F);
        // health test: four equal raw samples in a row trip the flag and block the word
        run(64'h0557_D555, '1, 26);
        chk("rct_fail_at", 64'(fail_at), 64'(17));
        chk("rct_nvalid", 64'(nvalid), 64'h0);
        chk("rct_sticky", 64'(rct_fail), 64'h1);
        idle();
        chk("rct_cleared", 64'(rct_fail), 64'h0);
        // enable drop after 5 zero bits; next word holds only post-resume 1s
        run(64'h2AAA_AAAA, ~64'h400, 28);
        idle();
        chk("endrop_seen", 64'(seen), 64'h1);
        chk("endrop_data", 64'(seen_data), 64'hFF);
        // backpressure: first word FF held, second word 00 waits, extra 1s dropped
        bus.data_ready = 1'b0;
        run(64'h5_5555, '1, 18);
        chk("bp_w1_valid", 64'(bus.data_valid), 64'h1);
        chk("bp_w1_data", 64'(bus.data), 64'hFF);
        run(64'h0155_AAAA, '1, 24);
        chk("bp_hold_data", 64'(bus.data), 64'hFF);
        chk("bp_hold_valid", 64'(bus.data_valid), 64'h1);
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        chk("bp_w2_data", 64'(bus.data), 64'h00);
        chk("bp_w2_valid", 64'(bus.data_valid), 64'h1);
        bus.data_ready = 1'b1;
        idle();
        chk("bp_drain_valid", 64'(bus.data_valid), 64'h0);
        // asynchronous reset with a word pending and a partial word collected
        bus.data_ready = 1'b0;
        run(64'h5_5555, '1, 18);
        chk("ar_pre_valid", 64'(bus.data_valid), 64'h1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_data", 64'(bus.data), 64'h0);
        chk("ar_valid", 64'(bus.data_valid), 64'h0);
        enable = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        bus.data_ready = 1'b1;
        run(64'hA_AAAA, '1, 18);
        idle();
        chk("ar_next_seen", 64'(seen), 64'h1);
        chk("ar_next_data", 64'(seen_data), 64'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
